// File: rtl/aq_djpeg_rasterbuf_if.sv
// Pixel stream bundle for aq_djpeg_rasterbuf: block-order input with back-pressure,
// raster-order valid/ready output with frame marks, and status flags.
interface aq_djpeg_rasterbuf_if #(
  parameter int unsigned PW = 24
);
  logic          in_start;
  logic [15:0]   in_width;
  logic [15:0]   in_height;
  logic          in_enable;
  logic [15:0]   in_x;
  logic [15:0]   in_y;
  logic [PW-1:0] in_data;
  logic          in_full;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_x;
  logic [15:0]   out_y;
  logic [PW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          idle;
  logic          ovf_err;

  modport master (
    output in_start, in_width, in_height, in_enable, in_x, in_y, in_data, out_ready,
    input  in_full, out_valid, out_x, out_y, out_data, out_sof, out_eol, out_eof,
           idle, ovf_err
  );

  modport slave (
    input  in_start, in_width, in_height, in_enable, in_x, in_y, in_data, out_ready,
    output in_full, out_valid, out_x, out_y, out_data, out_sof, out_eol, out_eof,
           idle, ovf_err
  );
endinterface

// File: rtl/aq_djpeg_rasterbuf.sv
// MCU-band to raster reorder buffer: two banks of MCU_H lines, one filling while the other drains.
// Define AQ_DJPEG_RASTERBUF_OVF_EN to flag writes presented while in_full (sticky ovf_err).
module aq_djpeg_rasterbuf #(
  parameter int unsigned MAX_WIDTH = 2048,
  parameter int unsigned MCU_H     = 16,
  parameter int unsigned CH        = 3,
  parameter int unsigned CW        = 8
) (
  input logic               clk,
  input logic               rst,
  aq_djpeg_rasterbuf_if.slave io
);
  localparam int unsigned PW   = CH * CW;
  localparam int unsigned XW   = $clog2(MAX_WIDTH);
  localparam int unsigned LW   = $clog2(MCU_H);
  localparam int unsigned AW   = 1 + LW + XW;
  localparam int unsigned CNTW = LW + XW + 1;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        bend;
    logic        bank;
  } meta_t;

  typedef struct packed {
    logic [PW-1:0] data;
    meta_t         m;
  } ent_t;

  logic [PW-1:0]   mem_q [2**AW];
  logic [PW-1:0]   rdata_q;

  logic            active_q, active_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     height_q, height_d;
  bank_e           bank_q [2];
  bank_e           bank_d [2];
  logic [CNTW-1:0] cnt_q [2];
  logic [CNTW-1:0] cnt_d [2];
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic            in_full_q, in_full_d;
  logic            rd_busy_q, rd_busy_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     ry_q, ry_d;
  logic [LW-1:0]   rl_q, rl_d;
  logic            rd_pend_q, rd_pend_d;
  meta_t           pm_q, pm_d;
  ent_t            f_q [2];
  ent_t            f_d [2];
  logic [1:0]      fcnt_q, fcnt_d;

  logic            wr_bank, wr_en, rd_bank, rd_can, rd_en, pop;
  logic [15:0]     band_base, rows_rem, wr_rows;
  logic [31:0]     wr_target;
  logic [AW-1:0]   waddr, raddr;
  meta_t           rd_meta;

  // Write side: band bank comes from in_y, rows clipped for a truncated last band.
  always_comb begin
    wr_bank   = io.in_y[LW];
    band_base = {io.in_y[15:LW], {LW{1'b0}}};
    rows_rem  = height_q - band_base;
    wr_rows   = (rows_rem > 16'(MCU_H)) ? 16'(MCU_H) : rows_rem;
    wr_target = 32'(width_q) * 32'(wr_rows);
    wr_en     = active_q && !io.in_start && io.in_enable && !in_full_q &&
                (io.in_x < width_q) && (io.in_y < height_q) &&
                (bank_q[wr_bank] == B_EMPTY || bank_q[wr_bank] == B_FILLING);
    waddr     = {wr_bank, io.in_y[LW-1:0], io.in_x[XW-1:0]};
  end

  // Read side: reads are issued only while the skid buffer has room for the in-flight word.
  always_comb begin
    rd_bank      = rb_q;
    pop          = (fcnt_q != 2'd0) && io.out_ready;
    rd_can       = active_q && !io.in_start && (rd_busy_q || bank_q[rd_bank] == B_FULL);
    rd_en        = rd_can && (int'(fcnt_q) + int'(rd_pend_q) - int'(pop) < 2);
    raddr        = {rd_bank, rl_q, rx_q[XW-1:0]};
    rd_meta.x    = rx_q;
    rd_meta.y    = ry_q;
    rd_meta.sof  = (rx_q == 16'd0) && (ry_q == 16'd0);
    rd_meta.eol  = (rx_q == width_q - 16'd1);
    rd_meta.eof  = rd_meta.eol && (ry_q == height_q - 16'd1);
    rd_meta.bend = rd_meta.eol && ((rl_q == LW'(MCU_H - 1)) || (ry_q == height_q - 16'd1));
    rd_meta.bank = rd_bank;
  end

  always_comb begin
    active_d  = active_q;
    width_d   = width_q;
    height_d  = height_q;
    bank_d    = bank_q;
    cnt_d     = cnt_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    rd_busy_d = rd_busy_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    rl_d      = rl_q;
    rd_pend_d = rd_en;
    pm_d      = pm_q;
    f_d       = f_q;
    fcnt_d    = fcnt_q;

    if (wr_en) begin
      if (32'(cnt_q[wr_bank]) + 32'd1 == wr_target) begin
        cnt_d[wr_bank]  = '0;
        bank_d[wr_bank] = B_FULL;
        wb_d            = ~wr_bank;
      end else begin
        cnt_d[wr_bank]  = cnt_q[wr_bank] + 1'b1;
        bank_d[wr_bank] = B_FILLING;
      end
    end

    if (rd_en) begin
      bank_d[rd_bank] = B_DRAINING;
      pm_d            = rd_meta;
      rd_busy_d       = !rd_meta.bend;
      if (rd_meta.eol) begin
        rx_d = '0;
        ry_d = ry_q + 16'd1;
        rl_d = rl_q + LW'(1);
      end else begin
        rx_d = rx_q + 16'd1;
      end
      if (rd_meta.bend) begin
        rl_d = '0;
        rb_d = ~rb_q;
      end
    end

    // Bank frees only when its last pixel leaves the skid buffer, not when it is read.
    if (pop) begin
      f_d[0] = f_q[1];
      fcnt_d = fcnt_q - 2'd1;
      if (f_q[0].m.bend) bank_d[f_q[0].m.bank] = B_EMPTY;
      if (f_q[0].m.eof)  active_d = 1'b0;
    end

    if (rd_pend_q) begin
      f_d[fcnt_d[0]] = '{data: rdata_q, m: pm_q};
      fcnt_d         = fcnt_d + 2'd1;
    end

    in_full_d = (bank_d[wb_d] == B_FULL) || (bank_d[wb_d] == B_DRAINING);

    if (io.in_start) begin
      active_d  = 1'b1;
      width_d   = io.in_width;
      height_d  = io.in_height;
      bank_d    = '{B_EMPTY, B_EMPTY};
      cnt_d     = '{default: '0};
      wb_d      = 1'b0;
      rb_d      = 1'b0;
      rd_busy_d = 1'b0;
      rx_d      = '0;
      ry_d      = '0;
      rl_d      = '0;
      rd_pend_d = 1'b0;
      fcnt_d    = '0;
      in_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      bank_q    <= '{B_EMPTY, B_EMPTY};
      cnt_q     <= '{default: '0};
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      in_full_q <= 1'b0;
      rd_busy_q <= 1'b0;
      rx_q      <= '0;
      ry_q      <= '0;
      rl_q      <= '0;
      rd_pend_q <= 1'b0;
      pm_q      <= '0;
      f_q       <= '{default: '0};
      fcnt_q    <= '0;
    end else begin
      active_q  <= active_d;
      width_q   <= width_d;
      height_q  <= height_d;
      bank_q    <= bank_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      in_full_q <= in_full_d;
      rd_busy_q <= rd_busy_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      rl_q      <= rl_d;
      rd_pend_q <= rd_pend_d;
      pm_q      <= pm_d;
      f_q       <= f_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= io.in_data;
    if (rd_en) rdata_q <= mem_q[raddr];
  end

`ifdef AQ_DJPEG_RASTERBUF_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst || io.in_start) ovf_q <= 1'b0;
    else if (active_q && io.in_enable && in_full_q) ovf_q <= 1'b1;
  end
  assign io.ovf_err = ovf_q;
`else
  assign io.ovf_err = 1'b0;
`endif

  assign io.in_full   = in_full_q;
  assign io.out_valid = (fcnt_q != 2'd0);
  assign io.out_x     = f_q[0].m.x;
  assign io.out_y     = f_q[0].m.y;
  assign io.out_data  = f_q[0].data;
  assign io.out_sof   = f_q[0].m.sof;
  assign io.out_eol   = f_q[0].m.eol;
  assign io.out_eof   = f_q[0].m.eof;
  assign io.idle      = !active_q && (bank_q[0] == B_EMPTY) && (bank_q[1] == B_EMPTY);
endmodule

// File: tb/tb_aq_djpeg_rasterbuf.sv
// Directed bench for aq_djpeg_rasterbuf (MAX_WIDTH=32, MCU_H=8, 24-bit pixels).
// Pixels carry {frame id, y, x}, so any reorder, loss or stale data shows in the beat compare.
module tb_aq_djpeg_rasterbuf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fid = 0;
  int   mon_x, mon_y, mon_w, mon_h, mon_beats;
  logic mon_en = 1'b0;
  logic rnd_ready = 1'b0;
  logic t3_watch = 1'b0;
  logic saw_full = 1'b0;
  logic exp_ovf;

  aq_djpeg_rasterbuf_if #(.PW(24)) bus ();

  aq_djpeg_rasterbuf #(.MAX_WIDTH(32), .MCU_H(8), .CH(3), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    return {8'(fid), 8'(y), 8'(x)};
  endfunction

  // Scoreboard: every valid cycle the head must equal the next raster pixel (covers stalls).
  always @(negedge clk) begin
    if (t3_watch && bus.in_full) saw_full = 1'b1;
    if (mon_en && bus.out_valid) begin
      if (mon_beats >= mon_w * mon_h) begin
        check("extra_beat", 64'(bus.out_valid), 64'd0);
      end else begin
        check("beat",
              64'({bus.out_x, bus.out_y, bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof}),
              64'({16'(mon_x), 16'(mon_y), pix(mon_x, mon_y),
                   (mon_x == 0 && mon_y == 0), (mon_x == mon_w - 1),
                   (mon_x == mon_w - 1 && mon_y == mon_h - 1)}));
        if (bus.out_ready) begin
          mon_beats++;
          if (mon_x == mon_w - 1) begin
            mon_x = 0;
            mon_y++;
          end else begin
            mon_x++;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) bus.out_ready = ($urandom_range(0, 99) >= 30);
  end

  task automatic start_frame(input int w, input int h);
    fid++;
    mon_w = w; mon_h = h; mon_x = 0; mon_y = 0; mon_beats = 0;
    bus.in_start  = 1'b1;
    bus.in_width  = 16'(w);
    bus.in_height = 16'(h);
    @(posedge clk) #1;
    bus.in_start  = 1'b0;
  endtask

  task automatic wr_px(input int x, input int y);
    for (int i = 0; i < 3000 && bus.in_full; i++) @(posedge clk) #1;
    if (bus.in_full) check("wr_stall", 64'(bus.in_full), 64'd0);
    bus.in_enable = 1'b1;
    bus.in_x      = 16'(x);
    bus.in_y      = 16'(y);
    bus.in_data   = pix(x, y);
    @(posedge clk) #1;
    bus.in_enable = 1'b0;
  endtask

  // Block order: 8x8 blocks left to right across a band, bands top to bottom.
  task automatic send_range(input int wp, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      int bpr, blk, inb;
      bpr = wp / 8;
      blk = k / 64;
      inb = k % 64;
      wr_px((blk % bpr) * 8 + inb % 8, (blk / bpr) * 8 + inb / 8);
    end
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget, input logic frame_end);
    for (int i = 0; i < budget && mon_beats < n; i++) @(posedge clk) #1;
    check(tag, 64'(mon_beats), 64'(n));
    if (frame_end) check({tag, "_idle"}, 64'(bus.idle), 64'd1);
  endtask

  initial begin
`ifdef AQ_DJPEG_RASTERBUF_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    bus.in_start = 1'b0; bus.in_width = '0; bus.in_height = '0; bus.in_enable = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_idle", 64'(bus.idle), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_full", 64'(bus.in_full), 64'd0);
    check("rst_ovf", 64'(bus.ovf_err), 64'd0);
    check("rst_marks", 64'({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data}), 64'd0);
    mon_en = 1'b1;

    // 16x16, two full bands, sink always ready.
    bus.out_ready = 1'b1;
    start_frame(16, 16);
    check("start_idle", 64'(bus.idle), 64'd0);
    send_range(16, 0, 256);
    wait_beats("t1_beats", 256, 2000, 1'b1);

    // 20x10 with MCU padding; sink held off so band 1 completion raises in_full.
    bus.out_ready = 1'b0;
    start_frame(20, 10);
    send_range(24, 0, 192);
    check("t2_band0_full", 64'(bus.in_full), 64'd0);
    send_range(24, 192, 331);
    check("t2_before40", 64'(bus.in_full), 64'd0);
    send_range(24, 331, 332);
    check("t2_after40", 64'(bus.in_full), 64'd1);
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    send_range(24, 332, 384);
    wait_beats("t2_beats", 200, 2000, 1'b1);

    // 32x32 with ~30% random stalls.
    start_frame(32, 32);
    rnd_ready = 1'b1;
    t3_watch = 1'b1;
    send_range(32, 0, 1024);
    wait_beats("t3_beats", 1024, 6000, 1'b1);
    check("t3_saw_full", 64'(saw_full), 64'd1);
    t3_watch = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk) #2;
    bus.out_ready = 1'b0;

    // Write presented while in_full must be dropped.
    start_frame(8, 24);
    send_range(8, 0, 128);
    check("t4_full", 64'(bus.in_full), 64'd1);
    check("t4_ovf_pre", 64'(bus.ovf_err), 64'd0);
    bus.in_enable = 1'b1; bus.in_x = 16'd3; bus.in_y = 16'd17; bus.in_data = 24'hBAD0BA;
    @(posedge clk) #1;
    bus.in_enable = 1'b0;
    @(posedge clk) #1;
    check("t4_ovf", 64'(bus.ovf_err), 64'(exp_ovf));
    bus.out_ready = 1'b1;
    send_range(8, 128, 192);
    wait_beats("t4_beats", 192, 2000, 1'b1);
    check("t4_ovf_sticky", 64'(bus.ovf_err), 64'(exp_ovf));

    // Restart in the middle of draining band 1.
    start_frame(16, 16);
    check("t5_ovf_clr", 64'(bus.ovf_err), 64'd0);
    send_range(16, 0, 256);
    wait_beats("t5_mid", 140, 2000, 1'b0);
    check("t5_mid_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    mon_en = 1'b0;
    start_frame(8, 8);
    check("t5_valid_drop", 64'(bus.out_valid), 64'd0);
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    send_range(8, 0, 64);
    wait_beats("t5_beats", 64, 2000, 1'b1);

    // 1x1 frame: latency of two cycles, then idle right after acceptance.
    start_frame(1, 1);
    wr_px(0, 0);
    check("t6_lat0", 64'(bus.out_valid), 64'd0);
    @(posedge clk) #1;
    check("t6_lat1", 64'(bus.out_valid), 64'd0);
    @(posedge clk) #1;
    check("t6_lat2", 64'(bus.out_valid), 64'd1);
    check("t6_idle_pre", 64'(bus.idle), 64'd0);
    @(posedge clk) #1;
    check("t6_beats", 64'(mon_beats), 64'd1);
    check("t6_idle", 64'(bus.idle), 64'd1);
    check("t6_valid_end", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
